amm_burst_slave_mem: RTL and testbench

Avalon-MM burst slave memory model that consumes the master side of the team's Avalon-MM interface bundle (address/read/write/byteenable/burstcount/writedata in; readdata/readdatavalid/waitrequest out). It is the downstream target the memory checker's master drives in self-checking benches and in the loopback build. It provides word-addressed storage with byte-enable writes, linear bursts, a fixed read latency, and a one-cycle error pulse for illegal commands.

---
 rtl/amm_burst_slave_mem_if.sv | 29 ++
 rtl/amm_burst_slave_mem.sv | 169 ++++++++++++++++
 tb/tb_amm_burst_slave_mem.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amm_burst_slave_mem_if.sv
// Avalon-MM burst bus bundle shared by the memory checker master and the
// burst slave memory model. cmd_err travels with the bus so that the slave
// reports illegal commands on the same bundle that carries them.
interface amm_burst_slave_mem_if #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BURST_W = 11
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;
  logic                cmd_err;

  modport master (
    output address, read, write, byteenable, burstcount, writedata,
    input  readdata, readdatavalid, waitrequest, cmd_err
  );

  modport slave (
    input  address, read, write, byteenable, burstcount, writedata,
    output readdata, readdatavalid, waitrequest, cmd_err
  );
endinterface

// File: rtl/amm_burst_slave_mem.sv
// Avalon-MM burst slave memory model: word-addressed storage with byte-enable
// writes, linear wrapping bursts, fixed read latency and a one-cycle error
// pulse for illegal commands. All outputs are registered.
module amm_burst_slave_mem #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BURST_W      = 11,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  amm_burst_slave_mem_if.slave   bus
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LAT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_WAIT,
    ST_RD_BURST
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [BURST_W-1:0]  rem_q, rem_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                rdv_q, rdv_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                wait_q, wait_d;
  logic                err_q, err_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Control registers; reset aborts any burst and holds the bus stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      wait_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Storage array: byte-merged writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (bus.byteenable[b]) begin
          mem_q[mem_waddr][8*b +: 8] <= bus.writedata[8*b +: 8];
        end
      end
    end
  end

  // Command decode, burst sequencing and read-beat generation.
  // A read burst lingers one cycle in ST_RD_BURST with rem_q==0 after its
  // last beat so that waitrequest drops only once readdatavalid has ended.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    lat_d     = lat_q;
    rdv_d     = 1'b0;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;

    case (state_q)
      ST_IDLE: begin
        wait_d = 1'b0;
        if (!wait_q) begin
          if (bus.write) begin
            if (bus.burstcount == '0) begin
              err_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = bus.address;
              err_d     = bus.read;
              if (bus.burstcount != BURST_W'(1)) begin
                state_d = ST_WR_BURST;
                ptr_d   = bus.address + ADDR_W'(1);
                rem_d   = bus.burstcount - BURST_W'(1);
              end
            end
          end else if (bus.read) begin
            if (bus.burstcount == '0) begin
              err_d = 1'b1;
            end else begin
              state_d = ST_RD_WAIT;
              ptr_d   = bus.address;
              rem_d   = bus.burstcount;
              lat_d   = LAT_W'(READ_LATENCY - 1);
              wait_d  = 1'b1;
            end
          end
        end
      end

      ST_WR_BURST: begin
        wait_d = 1'b0;
        err_d  = bus.read;
        if (bus.write) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + ADDR_W'(1);
          rem_d  = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RD_WAIT: begin
        wait_d = 1'b1;
        if (lat_q != '0) begin
          lat_d = lat_q - LAT_W'(1);
        end else begin
          state_d = ST_RD_BURST;
          rdv_d   = 1'b1;
          rdata_d = mem_q[ptr_q];
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - BURST_W'(1);
        end
      end

      ST_RD_BURST: begin
        if (rem_q == '0) begin
          state_d = ST_IDLE;
          wait_d  = 1'b0;
        end else begin
          wait_d  = 1'b1;
          rdv_d   = 1'b1;
          rdata_d = mem_q[ptr_q];
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - BURST_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rdv_q;
  assign bus.waitrequest   = wait_q;
  assign bus.cmd_err       = err_q;

endmodule

// File: tb/tb_amm_burst_slave_mem.sv
// Self-checking bench for amm_burst_slave_mem: table-driven byte-merge
// vectors, hand-written corner sequences, and randomized bursts against a
// word-array reference model.
module tb_amm_burst_slave_mem;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BURST_W = 11;
  localparam int          L       = 2;
  localparam int          DEPTH   = 16;

  logic clk;
  logic rst_n;

  amm_burst_slave_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

  amm_burst_slave_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BURST_W(BURST_W),
    .READ_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int rdv_seen = 0;
  int exp_err = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] rd_beats [$];
  logic [31:0] wd [DEPTH];
  logic [3:0]  wbe [DEPTH];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] fill;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  always @(negedge clk) begin
    if (bus.cmd_err === 1'b1) err_seen++;
    if (bus.readdatavalid === 1'b1) rdv_seen++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int i);
    if (rd_beats.size() > i) return rd_beats[i];
    return 'x;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.burstcount = '0;
    bus.byteenable = '0;
    bus.writedata  = '0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (bus.waitrequest !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.waitrequest !== 1'b0) check(nm, 64'(bus.waitrequest), 64'd0);
  endtask

  // n-beat write from address a using wd/wbe; optional idle beat before beat gap_at.
  task automatic write_burst(input logic [3:0] a, input int n, input int gap_at);
    wait_ready("wr_ready_timeout");
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bus.write = 1'b0;
        @(negedge clk);
        check("wr_gap_wait_low", 64'(bus.waitrequest), 64'd0);
      end
      check("wr_wait_low", 64'(bus.waitrequest), 64'd0);
      bus.write      = 1'b1;
      bus.read       = 1'b0;
      bus.address    = (i == 0) ? a : 4'($urandom);
      bus.burstcount = (i == 0) ? BURST_W'(n) : BURST_W'($urandom);
      bus.writedata  = wd[i];
      bus.byteenable = wbe[i];
      @(negedge clk);
      model[(int'(a) + i) % DEPTH] = merge(model[(int'(a) + i) % DEPTH], wd[i], wbe[i]);
    end
    idle_inputs();
  endtask

  // n-beat read; checks latency, gap-free beats and waitrequest release.
  task automatic read_burst(input logic [3:0] a, input int n);
    int cyc, first, last;
    rd_beats.delete();
    bus.write = 1'b0;
    wait_ready("rd_ready_timeout");
    bus.address    = a;
    bus.read       = 1'b1;
    bus.burstcount = BURST_W'(n);
    @(negedge clk);
    bus.read       = 1'($urandom);
    bus.write      = 1'($urandom);
    bus.address    = 4'($urandom);
    bus.burstcount = BURST_W'($urandom);
    bus.writedata  = $urandom;
    bus.byteenable = 4'($urandom);
    cyc = 0; first = -1; last = -1;
    while (rd_beats.size() < n && cyc < L + n + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("rd_wait_busy", 64'(bus.waitrequest), 64'd1);
      if (bus.readdatavalid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        rd_beats.push_back(bus.readdata);
      end
    end
    idle_inputs();
    check("rd_latency", 64'(first), 64'(L));
    check("rd_contiguous", 64'(last - first + 1), 64'(n));
    check("rd_wait_last_beat", 64'(bus.waitrequest), 64'd1);
    @(negedge clk);
    check("rd_wait_release", 64'(bus.waitrequest), 64'd0);
    check("rd_valid_end", 64'(bus.readdatavalid), 64'd0);
  endtask

  task automatic compare_model(input logic [3:0] a, input int n, input string nm);
    for (int i = 0; i < n; i++) check(nm, 64'(beat(i)), 64'(model[(int'(a) + i) % DEPTH]));
  endtask

  initial begin
    int e0, r0, rr;
    vecs[0] = '{4'd3,  32'h0000_0000, 32'hA5A5_1234, 4'hF, 32'hA5A5_1234};
    vecs[1] = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0000, 4'h5, 32'hFF00_FF00};
    vecs[2] = '{4'd0,  32'h1234_5678, 32'hAABB_CCDD, 4'h8, 32'hAA34_5678};
    vecs[3] = '{4'd15, 32'h0000_0000, 32'hDEAD_BEEF, 4'h3, 32'h0000_BEEF};
    vecs[4] = '{4'd7,  32'h1122_3344, 32'h0000_0000, 4'h0, 32'h1122_3344};
    vecs[5] = '{4'd9,  32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'hA, 32'hF00F_F00F};

    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_waitrequest", 64'(bus.waitrequest), 64'd1);
    check("rst_readdatavalid", 64'(bus.readdatavalid), 64'd0);
    check("rst_readdata", 64'(bus.readdata), 64'd0);
    check("rst_cmd_err", 64'(bus.cmd_err), 64'd0);
    rst_n = 1'b1;
    check("rst_release_wait_hold", 64'(bus.waitrequest), 64'd1);
    @(negedge clk);
    check("rst_release_wait_low", 64'(bus.waitrequest), 64'd0);

    // Fill all 16 words with a single wrapping burst starting mid-array.
    for (int i = 0; i < DEPTH; i++) begin
      wd[i]  = $urandom;
      wbe[i] = 4'hF;
    end
    write_burst(4'd6, DEPTH, -1);
    read_burst(4'd6, DEPTH);
    compare_model(4'd6, DEPTH, "init_fill_data");

    // Table: fill word, partial write, single read.
    foreach (vecs[k]) begin
      wd[0] = vecs[k].fill;  wbe[0] = 4'hF;
      write_burst(vecs[k].addr, 1, -1);
      wd[0] = vecs[k].wdata; wbe[0] = vecs[k].be;
      write_burst(vecs[k].addr, 1, -1);
      read_burst(vecs[k].addr, 1);
      check("vec_readback", 64'(beat(0)), 64'(vecs[k].exp));
    end

    // Wrapping 4-beat write burst with an idle beat, read back as a burst.
    for (int i = 0; i < 4; i++) begin
      wd[i]  = 32'h10 + 32'(i);
      wbe[i] = 4'hF;
    end
    write_burst(4'd14, 4, 2);
    read_burst(4'd14, 4);
    for (int i = 0; i < 4; i++) check("wrap_burst_data", 64'(beat(i)), 64'h10 + 64'(i));

    // burstcount=0 read: dropped with one error pulse, no data.
    repeat (2) @(negedge clk);
    e0 = err_seen; r0 = rdv_seen;
    bus.read = 1'b1; bus.address = 4'd2; bus.burstcount = '0;
    @(negedge clk);
    idle_inputs();
    repeat (L + 4) @(negedge clk);
    exp_err++;
    check("bc0_read_err", 64'(err_seen - e0), 64'd1);
    check("bc0_read_no_rdv", 64'(rdv_seen - r0), 64'd0);
    check("bc0_read_wait", 64'(bus.waitrequest), 64'd0);

    // burstcount=0 write: dropped, memory unchanged.
    e0 = err_seen;
    bus.write = 1'b1; bus.address = 4'd4; bus.burstcount = '0;
    bus.writedata = 32'hDEAD_0000; bus.byteenable = 4'hF;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    exp_err++;
    check("bc0_write_err", 64'(err_seen - e0), 64'd1);
    read_burst(4'd4, 1);
    compare_model(4'd4, 1, "bc0_write_not_stored");

    // read and write together: write stored, read dropped, one error.
    repeat (2) @(negedge clk);
    e0 = err_seen; r0 = rdv_seen;
    bus.write = 1'b1; bus.read = 1'b1; bus.address = 4'd6; bus.burstcount = BURST_W'(1);
    bus.writedata = 32'h55AA_0F0F; bus.byteenable = 4'hF;
    @(negedge clk);
    idle_inputs();
    model[6] = 32'h55AA_0F0F;
    repeat (L + 4) @(negedge clk);
    exp_err++;
    check("rdwr_err", 64'(err_seen - e0), 64'd1);
    check("rdwr_no_rdv", 64'(rdv_seen - r0), 64'd0);
    read_burst(4'd6, 1);
    check("rdwr_write_stored", 64'(beat(0)), 64'h55AA_0F0F);

    // read asserted during a write burst: ignored, error pulse, beat stored.
    e0 = err_seen;
    bus.write = 1'b1; bus.address = 4'd10; bus.burstcount = BURST_W'(2);
    bus.writedata = 32'hCAFE_0001; bus.byteenable = 4'hF;
    @(negedge clk);
    bus.read = 1'b1; bus.writedata = 32'hCAFE_0002;
    @(negedge clk);
    idle_inputs();
    model[10] = 32'hCAFE_0001; model[11] = 32'hCAFE_0002;
    repeat (3) @(negedge clk);
    exp_err++;
    check("wrburst_read_err", 64'(err_seen - e0), 64'd1);
    read_burst(4'd10, 2);
    compare_model(4'd10, 2, "wrburst_read_data");

    // Maximum-length read burst, wrapping the array many times.
    read_burst(4'd1, 1024);
    compare_model(4'd1, 1024, "max_burst_data");

    // Reset during beat 2 of an 8-beat read.
    wait_ready("rstmid_ready_timeout");
    bus.read = 1'b1; bus.address = 4'd0; bus.burstcount = BURST_W'(8);
    @(negedge clk);
    idle_inputs();
    rr = 0;
    for (int c = 0; c < 20 && rr < 2; c++) begin
      @(negedge clk);
      if (bus.readdatavalid === 1'b1) rr++;
    end
    check("rstmid_reached_beat2", 64'(rr), 64'd2);
    rst_n = 1'b0;
    #1;
    check("rstmid_rdv_async", 64'(bus.readdatavalid), 64'd0);
    check("rstmid_wait_async", 64'(bus.waitrequest), 64'd1);
    @(negedge clk);
    check("rstmid_wait_in_reset", 64'(bus.waitrequest), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_wait_release", 64'(bus.waitrequest), 64'd0);
    check("rstmid_rdv_idle", 64'(bus.readdatavalid), 64'd0);
    read_burst(4'd0, 8);
    compare_model(4'd0, 8, "rstmid_reread");

    // Randomized bursts against the reference model.
    for (int it = 0; it < 60; it++) begin
      logic [3:0] a;
      int n, gap;
      a = 4'($urandom);
      n = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) begin
          wd[i]  = $urandom;
          wbe[i] = 4'($urandom);
        end
        gap = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
        write_burst(a, n, gap);
      end else begin
        read_burst(a, n);
        compare_model(a, n, "rnd_read_data");
      end
    end

    repeat (3) @(negedge clk);
    check("total_cmd_err_pulses", 64'(err_seen), 64'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
